// File: rtl/pipelined_rca_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder.
// The producer/consumer side uses the master modport; the adder uses slave.
interface pipelined_rca_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one STAGE_W-bit slice per stage,
// registered stage-boundary carries, whole pipeline stalls as a unit.
module pipelined_rca #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input logic            clk,
  input logic            rst,
  pipelined_rca_if.slave bus
);
  localparam int NSTAGES = WIDTH / STAGE_W;

  logic [NSTAGES-1:0] valid_q;
  logic [NSTAGES-1:0] valid_d;
  logic [NSTAGES-1:0] carry_q;
  logic [NSTAGES-1:0] carry_d;
  logic [WIDTH-1:0]   a_q   [NSTAGES];
  logic [WIDTH-1:0]   a_d   [NSTAGES];
  logic [WIDTH-1:0]   b_q   [NSTAGES];
  logic [WIDTH-1:0]   b_d   [NSTAGES];
  logic [WIDTH-1:0]   sum_q [NSTAGES];
  logic [WIDTH-1:0]   sum_d [NSTAGES];
  logic               ovf_q;
  logic               ovf_d;

  logic               adv_s;
  logic [WIDTH-1:0]   src_a_s;
  logic [WIDTH-1:0]   src_b_s;
  logic [WIDTH-1:0]   src_sum_s;
  logic               src_c_s;
  logic               src_v_s;
  logic [STAGE_W+1:0] slice_s;

  // Pure ripple over one slice; returns {carry into slice MSB, carry out, sum}.
  function automatic logic [STAGE_W+1:0] add_slice(
    input logic [STAGE_W-1:0] a,
    input logic [STAGE_W-1:0] b,
    input logic               c
  );
    logic [STAGE_W-1:0] s;
    logic               cy;
    logic               cm;
    s  = {STAGE_W{1'b0}};
    cy = c;
    cm = c;
    for (int i = 0; i < STAGE_W; i++) begin
      cm   = cy;
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    return {cm, cy, s};
  endfunction

  // Next-state of every stage; each stage resolves its own slice from the previous stage.
  always_comb begin
    adv_s     = !valid_q[NSTAGES-1] || bus.out_ready;
    valid_d   = valid_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    src_a_s   = {WIDTH{1'b0}};
    src_b_s   = {WIDTH{1'b0}};
    src_sum_s = {WIDTH{1'b0}};
    src_c_s   = 1'b0;
    src_v_s   = 1'b0;
    slice_s   = {(STAGE_W+2){1'b0}};
    for (int k = 0; k < NSTAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end
    if (adv_s) begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (k == 0) begin
          src_a_s   = bus.in_a;
          src_b_s   = bus.in_sub ? ~bus.in_b : bus.in_b;
          src_c_s   = bus.in_sub ? ~bus.in_cin : bus.in_cin;
          src_sum_s = {WIDTH{1'b0}};
          src_v_s   = bus.in_valid;
        end else begin
          src_a_s   = a_q[(k == 0) ? 0 : k - 1];
          src_b_s   = b_q[(k == 0) ? 0 : k - 1];
          src_c_s   = carry_q[(k == 0) ? 0 : k - 1];
          src_sum_s = sum_q[(k == 0) ? 0 : k - 1];
          src_v_s   = valid_q[(k == 0) ? 0 : k - 1];
        end
        slice_s  = add_slice(src_a_s[k*STAGE_W +: STAGE_W],
                             src_b_s[k*STAGE_W +: STAGE_W], src_c_s);
        valid_d[k] = src_v_s;
        carry_d[k] = slice_s[STAGE_W];
        a_d[k]     = src_a_s;
        b_d[k]     = src_b_s;
        sum_d[k]   = src_sum_s;
        sum_d[k][k*STAGE_W +: STAGE_W] = slice_s[STAGE_W-1:0];
      end
      // slice_s now holds the top slice, so its MSB carries give signed overflow.
      ovf_d = slice_s[STAGE_W+1] ^ slice_s[STAGE_W];
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline registers; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {NSTAGES{1'b0}};
      carry_q <= {NSTAGES{1'b0}};
      ovf_q   <= 1'b0;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = valid_q[NSTAGES-1];
  assign bus.out_sum   = sum_q[NSTAGES-1];
  assign bus.out_cout  = carry_q[NSTAGES-1];
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// Directed and streamed checks of pipelined_rca (WIDTH=16, STAGE_W=4, latency 4).
module tb_pipelined_rca;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipelined_rca_if #(.WIDTH(16)) bus ();

  pipelined_rca #(.WIDTH(16), .STAGE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ovf, cout, sum} from plain wide addition and operand signs
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] be;
    logic        c0;
    logic [16:0] r;
    logic        o;
    be = sub ? ~b : b;
    c0 = sub ? ~cin : cin;
    r  = {1'b0, a} + {1'b0, be} + {16'd0, c0};
    o  = (a[15] == be[15]) && (r[15] != a[15]);
    return {o, r};
  endfunction

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo);
    int lat;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.in_sub    = sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_val({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'd4);
    check_val({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
    check_val({tag, "_cout"}, 32'(bus.out_cout), 32'(ec));
    check_val({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
    step();
    check_val({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic        scin [8];
  logic        ssub [8];
  logic [17:0] exp_q [$];
  logic [17:0] got;
  logic [17:0] prev_out;
  logic [17:0] want;
  logic        prev_stall;
  int          sent;
  int          rcvd;
  int          cyc;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0000;
    bus.in_b      = 16'h0000;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sum", 32'(bus.out_sum), 32'd0);
    check_val("rst_cout", 32'(bus.out_cout), 32'd0);
    check_val("rst_ovf", 32'(bus.out_ovf), 32'd0);
    rst = 1'b0;
    #1;
    check_val("rst_rdy", 32'(bus.in_ready), 32'd1);

    run_one("add3p1",    16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0);
    run_one("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("wrap_cin",  16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    run_one("posovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("negovf",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_one("sub5m2",    16'h0005, 16'h0002, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0);
    run_one("sub2m5",    16'h0002, 16'h0005, 1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    run_one("sub5m2b",   16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_one("subovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Stream with out_ready pattern 1,0,0 repeating
    for (int i = 0; i < 8; i++) begin
      sa[i]   = 16'($urandom);
      sb[i]   = 16'($urandom);
      scin[i] = 1'($urandom_range(0, 1));
      ssub[i] = 1'($urandom_range(0, 1));
    end
    sent       = 0;
    rcvd       = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_out   = 18'd0;
    while (rcvd < 8 && cyc < 200) begin
      bus.out_ready = (cyc % 3 == 0);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in_a   = sa[sent];
        bus.in_b   = sb[sent];
        bus.in_cin = scin[sent];
        bus.in_sub = ssub[sent];
      end
      #1;
      got = {bus.out_ovf, bus.out_cout, bus.out_sum};
      check_val("strm_rdy", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) begin
        check_val("strm_hold_v", 32'(bus.out_valid), 32'd1);
        check_val("strm_hold", 32'(got), 32'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("strm_extra", 32'd1, 32'd0);
        end else begin
          want = exp_q.pop_front();
          check_val("strm_res", 32'(got), 32'(want));
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_add(sa[sent], sb[sent], scin[sent], ssub[sent]));
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = got;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_val("strm_count", 32'(rcvd), 32'd8);
    check_val("strm_left", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_a     = 16'(16'h0100 + i);
      bus.in_b     = 16'h0001;
      bus.in_cin   = 1'b0;
      bus.in_sub   = 1'b0;
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check_val("mrst_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("mrst_quiet", 32'(bus.out_valid), 32'd0);
    end
    run_one("post_rst",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
